add_sched256: RTL
=================

ADD_SCHED256 -- requirements
Module: add_sched256

Interface
REQ-001 Parameter N, default 256: operand width in bits.
REQ-002 Parameter W, default 64: adder slice width in bits; N SHALL be an integer multiple of W, and N/W SHALL be at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_cin, req0_a, req0_b  input  1, N, N  requester 0 carry-in and operands.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_cin, req1_a, req1_b, req1_ready  as REQ-005 to REQ-007, for requester 1.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_s  output  N  sum.
REQ-012 out_cout  output  1  carry-out of bit N-1.
REQ-013 out_id  output  1  index of the requester that owns the result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CALC and DONE; there are no other states.
REQ-016 IDLE: req0_ready and req1_ready SHALL be combinational grants; at most one is high; both are low outside IDLE.
REQ-017 Arbitration: one valid requester → that requester is granted. Both valid → the requester selected by the priority pointer ptr is granted.
REQ-018 On a grant to requester i, ptr SHALL become 1-i on the same edge; ptr SHALL hold otherwise.
REQ-019 Accept edge (grant high): latch a, b, cin and id = i; clear slice counter k to 0; go to CALC.
REQ-020 CALC: each cycle compute slice k as a[kW+W-1:kW] + b[kW+W-1:kW] + c with a single shared W-bit adder.
  - c = latched cin when k = 0, otherwise the carry register.
  - Register the W-bit sum into s[kW+W-1:kW] and the carry-out into the carry register.
  - Increment k.
REQ-021 After the edge that stores slice N/W-1, go to DONE; out_cout SHALL equal that slice's carry-out.
REQ-022 Latency: out_valid SHALL rise exactly N/W edges after the accept edge (4 for the defaults).
REQ-023 DONE: out_valid = 1. out_s, out_cout and out_id SHALL be stable until the output handshake.
REQ-024 out_valid & out_ready at an edge → IDLE; no new request is granted in that same cycle.
REQ-025 out_ready low in DONE → stay in DONE indefinitely, holding all outputs.
REQ-026 out_ready and req*_valid SHALL be ignored in CALC; a request valid in CALC or DONE waits and is not dropped.
REQ-027 Width rule: {out_cout, out_s} SHALL equal a + b + cin modulo 2^(N+1) for every operand pair.
REQ-028 The slice counter SHALL be ceil(log2(N/W)) bits wide; it does not wrap within one operation.
REQ-029 Operand inputs SHALL be sampled only on the accept edge; later changes SHALL have no effect on the result.

Reset
REQ-030 rst high at an edge SHALL force, irrespective of state:
  - state = IDLE, ptr = 0, k = 0, carry register = 0;
  - out_valid = 0, busy = 0, out_s = 0, out_cout = 0, out_id = 0.
REQ-031 Reset during CALC or DONE SHALL discard the operation in progress; no out_valid pulse for it SHALL ever appear.
REQ-032 req*_ready SHALL be low during any cycle in which rst is high.

Verification
REQ-033 Single op: req0 sends a = 2^256-1, b = 1, cin = 0 → out_valid rises 4 cycles after accept with out_s = 0, out_cout = 1, out_id = 0.
REQ-034 Slice carry chain: a = 2^64-1, b = 0, cin = 1 → out_s = 2^64, out_cout = 0; carry crosses only the slice-0/1 boundary.
REQ-035 Contention: both requesters held valid from reset → grants in order req0, req1, req0, req1; each result carries the matching out_id.
REQ-036 Backpressure: out_ready held low for 10 cycles in DONE → outputs stable, busy = 1, no grant; the first out_ready high → IDLE on the next edge.
REQ-037 Reset mid-op: rst asserted on the 2nd CALC cycle → next cycle busy = 0, out_valid = 0, ptr = 0; a following request completes correctly.
REQ-038 Random: 10^4 random a, b, cin with random valid and out_ready patterns → every result matches REQ-027 and no request is lost or duplicated.

Source files
------------

// File: rtl/add_sched256.sv
// Two-requester N-bit adder built around a single shared W-bit slice adder.
// Latency: out_valid rises N/W clock edges after the accept edge.
// Backpressure: requests wait (ready low) outside IDLE; the result is held in DONE until out_ready.
module add_sched256 #(
   parameter int N = 256,
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   // requester 0
   input  logic         req0_valid,
   input  logic         req0_cin,
   input  logic [N-1:0] req0_a,
   input  logic [N-1:0] req0_b,
   output logic         req0_ready,
   // requester 1
   input  logic         req1_valid,
   input  logic         req1_cin,
   input  logic [N-1:0] req1_a,
   input  logic [N-1:0] req1_b,
   output logic         req1_ready,
   // result
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_s,
   output logic         out_cout,
   output logic         out_id,
   output logic         busy
);

   // number of slices and slice-counter width
   localparam int NS = N / W;
   localparam int KW = $clog2(NS);
   localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // round-robin pointer: requester that wins when both are valid
   logic ptr_q, ptr_d;

   // latched operation
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic         cin_q, cin_d;
   logic         id_q, id_d;

   // slice sequencing and carry between slices
   logic [KW-1:0] k_q, k_d;
   logic          carry_q, carry_d;

   // result registers
   logic [N-1:0] s_q, s_d;
   logic         cout_q, cout_d;

   // shared slice adder
   logic [W-1:0] a_sl;
   logic [W-1:0] b_sl;
   logic         c_sl;
   logic [W:0]   sum_w;

   logic accept;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic; requests are only looked at in IDLE, out_ready only in DONE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            if (k_q == K_LAST) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // outputs and grants; grants are combinational in IDLE and suppressed during reset
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if ((state_q == ST_IDLE) && !rst) begin
         if (req0_valid && req1_valid) begin
            req0_ready = (ptr_q == 1'b0);
            req1_ready = (ptr_q == 1'b1);
         end else begin
            req0_ready = req0_valid;
            req1_ready = req1_valid;
         end
      end
      accept    = req0_ready | req1_ready;
      out_valid = (state_q == ST_DONE);
      busy      = (state_q != ST_IDLE);
      out_s     = s_q;
      out_cout  = cout_q;
      out_id    = id_q;
   end

   // select slice k of the latched operands; carry-in is cin on slice 0, else the carry register
   always_comb begin
      a_sl  = a_q[int'(k_q)*W +: W];
      b_sl  = b_q[int'(k_q)*W +: W];
      c_sl  = (k_q == '0) ? cin_q : carry_q;
      sum_w = {1'b0, a_sl} + {1'b0, b_sl} + {{W{1'b0}}, c_sl};
   end

   // datapath next values: latch on accept, accumulate one slice per CALC cycle
   always_comb begin
      ptr_d   = ptr_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      id_d    = id_q;
      k_d     = k_q;
      carry_d = carry_q;
      s_d     = s_q;
      cout_d  = cout_q;
      if (accept) begin
         // the loser of this grant gets priority next time
         ptr_d = req0_ready;
         id_d  = req1_ready;
         a_d   = req1_ready ? req1_a   : req0_a;
         b_d   = req1_ready ? req1_b   : req0_b;
         cin_d = req1_ready ? req1_cin : req0_cin;
         k_d   = '0;
      end else if (state_q == ST_CALC) begin
         s_d[int'(k_q)*W +: W] = sum_w[W-1:0];
         carry_d               = sum_w[W];
         if (k_q == K_LAST) begin
            // last slice: its carry-out is the result carry; k holds, no wrap
            cout_d = sum_w[W];
         end else begin
            k_d = k_q + 1'b1;
         end
      end
   end

   // datapath registers; reset discards any operation in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         id_q    <= 1'b0;
         k_q     <= '0;
         carry_q <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         id_q    <= id_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

endmodule
